// File: rtl/bm_pkg.sv
// bm_pkg: shared AHB-Lite encodings, master indices and address-phase bundle for the bus-matrix
// output stages. OUTSTAGE_RR_ARB_EN selects round-robin arbitration in bm_outstage_arbiter.
package bm_pkg;
    localparam int NUM_M   = 3;
    localparam int ADDR_W  = 32;
    localparam int M_ICODE = 0;
    localparam int M_DCODE = 1;
    localparam int M_SYS   = 2;

    typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11} htrans_e;

    typedef logic [NUM_M-1:0] mvec_t;

    typedef struct packed {
        logic [1:0]        htrans;
        logic [ADDR_W-1:0] haddr;
        logic              hwrite;
        logic [2:0]        hsize;
        logic [2:0]        hburst;
        logic [3:0]        hprot;
    } ahb_addr_t;

    function automatic logic [1:0] rr_idx(input logic [1:0] base, input int k);
        return 2'((int'(base) + k) % NUM_M);
    endfunction
endpackage

// File: rtl/bm_outstage_arbiter.sv
// bm_outstage_arbiter: grant register with burst hold; fixed priority DCODE > SYS > ICODE,
// or round-robin from a last-grant pointer when OUTSTAGE_RR_ARB_EN is defined.
module bm_outstage_arbiter
    import bm_pkg::*;
(
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  hready_i,
    input  logic [NUM_M-1:0]      hsel_i,
    input  logic [NUM_M-1:0][1:0] htrans_i,
    output logic [NUM_M-1:0]      req_o,
    output logic [NUM_M-1:0]      grant_o
);
    logic [NUM_M-1:0] grant_q, grant_d, pick, cont;
    logic             keep;

    always_comb begin
        for (int m = 0; m < NUM_M; m++) begin
            req_o[m] = hsel_i[m] & htrans_i[m][1];
            cont[m]  = hsel_i[m] & htrans_i[m][0];
        end
    end

    // BUSY and SEQ both carry htrans[0]: the owner is inside a burst
    assign keep = |(grant_q & cont);

`ifdef OUTSTAGE_RR_ARB_EN
    logic [1:0] last_q, last_d, pick_idx, idx;

    always_comb begin
        pick     = '0;
        pick_idx = last_q;
        idx      = '0;
        for (int k = NUM_M; k >= 1; k--) begin
            idx = rr_idx(last_q, k);
            if (req_o[idx]) begin
                pick     = mvec_t'(1) << idx;
                pick_idx = idx;
            end
        end
    end

    assign last_d = (hready_i && !keep && |pick) ? pick_idx : last_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) last_q <= 2'(M_SYS);
        else          last_q <= last_d;
    end
`else
    assign pick = req_o[M_DCODE] ? mvec_t'(1) << M_DCODE :
                  req_o[M_SYS]   ? mvec_t'(1) << M_SYS   :
                  req_o[M_ICODE] ? mvec_t'(1) << M_ICODE : '0;
`endif

    assign grant_d = (hready_i && !keep && |pick) ? pick : grant_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) grant_q <= '0;
        else          grant_q <= grant_d;
    end

    assign grant_o = grant_q;
endmodule

// File: rtl/ahblite_busmatrix_outputstage_ram.sv
// ahblite_busmatrix_outputstage_ram: RAM-port output stage arbitrating ICODE/DCODE/SYS onto one
// AHB-Lite slave; OUTSTAGE_RR_ARB_EN switches the arbiter to round-robin.
module ahblite_busmatrix_outputstage_ram
    import bm_pkg::*;
(
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL_ICODE,
    input  logic [ADDR_W-1:0] HADDR_ICODE,
    input  logic [1:0]        HTRANS_ICODE,
    input  logic              HWRITE_ICODE,
    input  logic [2:0]        HSIZE_ICODE,
    input  logic [2:0]        HBURST_ICODE,
    input  logic [3:0]        HPROT_ICODE,
    input  logic [31:0]       HWDATA_ICODE,
    output logic              ACTIVE_Outputstage_RAM_ICODE,
    input  logic              HSEL_DCODE,
    input  logic [ADDR_W-1:0] HADDR_DCODE,
    input  logic [1:0]        HTRANS_DCODE,
    input  logic              HWRITE_DCODE,
    input  logic [2:0]        HSIZE_DCODE,
    input  logic [2:0]        HBURST_DCODE,
    input  logic [3:0]        HPROT_DCODE,
    input  logic [31:0]       HWDATA_DCODE,
    output logic              ACTIVE_Outputstage_RAM_DCODE,
    input  logic              HSEL_SYS,
    input  logic [ADDR_W-1:0] HADDR_SYS,
    input  logic [1:0]        HTRANS_SYS,
    input  logic              HWRITE_SYS,
    input  logic [2:0]        HSIZE_SYS,
    input  logic [2:0]        HBURST_SYS,
    input  logic [3:0]        HPROT_SYS,
    input  logic [31:0]       HWDATA_SYS,
    output logic              ACTIVE_Outputstage_RAM_SYS,
    output logic              HSEL_RAM,
    output logic [ADDR_W-1:0] HADDR_RAM,
    output logic [1:0]        HTRANS_RAM,
    output logic              HWRITE_RAM,
    output logic [2:0]        HSIZE_RAM,
    output logic [2:0]        HBURST_RAM,
    output logic [3:0]        HPROT_RAM,
    output logic [31:0]       HWDATA_RAM,
    output logic              HREADY_RAM,
    input  logic              HREADYOUT_RAM
);
    logic [NUM_M-1:0]         hsel, req, grant, data_sel_q, data_sel_d;
    logic [NUM_M-1:0][1:0]    htrans;
    logic [NUM_M-1:0][31:0]   hwdata;
    ahb_addr_t [NUM_M-1:0]    ap;
    ahb_addr_t                sel_ap;
    logic [31:0]              sel_wdata;

    assign hsel   = {HSEL_SYS, HSEL_DCODE, HSEL_ICODE};
    assign htrans = {HTRANS_SYS, HTRANS_DCODE, HTRANS_ICODE};
    assign hwdata = {HWDATA_SYS, HWDATA_DCODE, HWDATA_ICODE};
    assign ap[M_ICODE] = {HTRANS_ICODE, HADDR_ICODE, HWRITE_ICODE, HSIZE_ICODE, HBURST_ICODE, HPROT_ICODE};
    assign ap[M_DCODE] = {HTRANS_DCODE, HADDR_DCODE, HWRITE_DCODE, HSIZE_DCODE, HBURST_DCODE, HPROT_DCODE};
    assign ap[M_SYS]   = {HTRANS_SYS, HADDR_SYS, HWRITE_SYS, HSIZE_SYS, HBURST_SYS, HPROT_SYS};

    bm_outstage_arbiter u_arb (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .hready_i (HREADYOUT_RAM),
        .hsel_i   (hsel),
        .htrans_i (htrans),
        .req_o    (req),
        .grant_o  (grant)
    );

    // grant and data_sel are one-hot or zero, so a priority scan acts as a plain mux
    always_comb begin
        sel_ap    = '0;
        sel_wdata = '0;
        for (int m = 0; m < NUM_M; m++) begin
            if (grant[m])      sel_ap    = ap[m];
            if (data_sel_q[m]) sel_wdata = hwdata[m];
        end
    end

    assign HSEL_RAM   = |(grant & hsel);
    assign HTRANS_RAM = HSEL_RAM ? sel_ap.htrans : IDLE;
    assign HADDR_RAM  = sel_ap.haddr;
    assign HWRITE_RAM = sel_ap.hwrite;
    assign HSIZE_RAM  = sel_ap.hsize;
    assign HBURST_RAM = sel_ap.hburst;
    assign HPROT_RAM  = sel_ap.hprot;
    assign HWDATA_RAM = sel_wdata;
    assign HREADY_RAM = HREADYOUT_RAM;

    assign {ACTIVE_Outputstage_RAM_SYS, ACTIVE_Outputstage_RAM_DCODE, ACTIVE_Outputstage_RAM_ICODE} = grant & hsel;

    assign data_sel_d = HREADYOUT_RAM ? (grant & req) : data_sel_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) data_sel_q <= '0;
        else          data_sel_q <= data_sel_d;
    end
endmodule
